branch_resolve_unit: RTL and testbench

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

---
 rtl/branch_resolve_unit.sv | 185 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves branches/jumps in EX. Produces a one-cycle predictor
//               update strobe with call/ret/jmp attributes and a front-end
//               flush on mispredict, then discards a fixed number of unstalled
//               wrong-path EX cycles. Keeps saturating branch and
//               mispredict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             ex_valid_i,
    input  logic             stall_i,
    input  logic [31:0]      ex_pc_i,
    input  logic             ex_is_cond_i,
    input  logic             ex_is_jal_i,
    input  logic             ex_is_jalr_i,
    input  logic [4:0]       ex_rd_i,
    input  logic [4:0]       ex_rs1_i,
    input  logic             ex_cond_taken_i,
    input  logic [31:0]      ex_target_i,
    input  logic             ex_pred_taken_i,
    input  logic [31:0]      ex_pred_pc_i,
    output logic             branch_request_o,
    output logic [31:0]      branch_source_o,
    output logic [31:0]      branch_target_o,
    output logic             branch_is_taken_o,
    output logic             branch_is_call_o,
    output logic             branch_is_ret_o,
    output logic             branch_is_jmp_o,
    output logic             branch_mispredict_o,
    output logic             flush_o,
    output logic [31:0]      redirect_pc_o,
    output logic [CNT_W-1:0] perf_branch_cnt_o,
    output logic [CNT_W-1:0] perf_mispred_cnt_o
);

    localparam logic [3:0] c_SHADOW_LOAD = 4'(SHADOW_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        SHADOW = 2'd2
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_shadow_cnt, w_shadow_cnt_nxt;

    logic             r_request, r_taken, r_call, r_ret, r_jmp, r_mispredict, r_flush;
    logic [31:0]      r_source, r_target, r_redirect;
    logic [CNT_W-1:0] r_branch_cnt, r_mispred_cnt;

    logic        w_accept, w_is_jalr, w_is_jal, w_is_jump, w_taken;
    logic        w_rd_link, w_rs1_link, w_call, w_ret, w_jmp, w_mispredict;
    logic [31:0] w_actual_next;

    // The fetch-time taken flag is not needed: the predicted PC alone decides.
    logic w_unused;
    assign w_unused = ex_pred_taken_i;

    // Classify the EX instruction and decide acceptance (jalr > jal > cond).
    always_comb begin
        w_accept      = ex_valid_i && !stall_i && (r_state == IDLE)
                        && (ex_is_cond_i || ex_is_jal_i || ex_is_jalr_i);
        w_is_jalr     = ex_is_jalr_i;
        w_is_jal      = ex_is_jal_i && !ex_is_jalr_i;
        w_is_jump     = w_is_jalr || w_is_jal;
        w_taken       = w_is_jump ? 1'b1 : ex_cond_taken_i;
        w_actual_next = w_taken ? ex_target_i : (ex_pc_i + 32'd4);
        w_rd_link     = (ex_rd_i == 5'd1) || (ex_rd_i == 5'd5);
        w_rs1_link    = (ex_rs1_i == 5'd1) || (ex_rs1_i == 5'd5);
        w_call        = w_is_jump && w_rd_link;
        w_ret         = w_is_jalr && w_rs1_link && !w_rd_link;
        w_jmp         = w_is_jump && !w_call && !w_ret;
        w_mispredict  = (w_actual_next != ex_pred_pc_i);
    end

    // Next-state logic: mispredict -> one flush cycle -> shadow countdown.
    always_comb begin
        w_state_nxt      = r_state;
        w_shadow_cnt_nxt = r_shadow_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept && w_mispredict) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                w_state_nxt      = SHADOW;
                w_shadow_cnt_nxt = c_SHADOW_LOAD;
            end
            SHADOW: begin
                if (!stall_i) begin
                    if (r_shadow_cnt <= 4'd1) begin
                        w_state_nxt      = IDLE;
                        w_shadow_cnt_nxt = 4'd0;
                    end else begin
                        w_shadow_cnt_nxt = r_shadow_cnt - 4'd1;
                    end
                end
            end
            default: begin
                w_state_nxt      = IDLE;
                w_shadow_cnt_nxt = 4'd0;
            end
        endcase
    end

    // State and shadow counter registers.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_state      <= IDLE;
            r_shadow_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_shadow_cnt <= w_shadow_cnt_nxt;
        end
    end

    // Registered update strobe/attributes; attributes hold between updates.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_request    <= 1'b0;
            r_source     <= 32'd0;
            r_target     <= 32'd0;
            r_taken      <= 1'b0;
            r_call       <= 1'b0;
            r_ret        <= 1'b0;
            r_jmp        <= 1'b0;
            r_mispredict <= 1'b0;
            r_flush      <= 1'b0;
            r_redirect   <= 32'd0;
        end else begin
            r_request <= w_accept;
            r_flush   <= w_accept && w_mispredict;
            if (w_accept) begin
                r_source     <= ex_pc_i;
                r_target     <= ex_target_i;
                r_taken      <= w_taken;
                r_call       <= w_call;
                r_ret        <= w_ret;
                r_jmp        <= w_jmp;
                r_mispredict <= w_mispredict;
                if (w_mispredict) begin
                    r_redirect <= w_actual_next;
                end
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_accept && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_accept && w_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign branch_request_o    = r_request;
    assign branch_source_o     = r_source;
    assign branch_target_o     = r_target;
    assign branch_is_taken_o   = r_taken;
    assign branch_is_call_o    = r_call;
    assign branch_is_ret_o     = r_ret;
    assign branch_is_jmp_o     = r_jmp;
    assign branch_mispredict_o = r_mispredict;
    assign flush_o             = r_flush;
    assign redirect_pc_o       = r_redirect;
    assign perf_branch_cnt_o   = r_branch_cnt;
    assign perf_mispred_cnt_o  = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed self-checking bench for branch_resolve_unit. Drives a
//               default-width instance and a 4-bit-counter instance in
//               parallel from the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk_i = 1'b0;
    logic        n_rst_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        stall_i = 1'b0;
    logic [31:0] ex_pc_i = '0;
    logic        ex_is_cond_i = 1'b0;
    logic        ex_is_jal_i = 1'b0;
    logic        ex_is_jalr_i = 1'b0;
    logic [4:0]  ex_rd_i = '0;
    logic [4:0]  ex_rs1_i = '0;
    logic        ex_cond_taken_i = 1'b0;
    logic [31:0] ex_target_i = '0;
    logic        ex_pred_taken_i = 1'b0;
    logic [31:0] ex_pred_pc_i = '0;

    logic        req, taken, call, ret, jmp, mp, flush;
    logic [31:0] src, tgt, redir;
    logic [31:0] br_cnt, mp_cnt;

    logic        req4, taken4, call4, ret4, jmp4, mp4, flush4;
    logic [31:0] src4, tgt4, redir4;
    logic [3:0]  br_cnt4, mp_cnt4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    branch_resolve_unit dut (
        .clk_i(clk_i), .n_rst_i(n_rst_i), .ex_valid_i(ex_valid_i), .stall_i(stall_i),
        .ex_pc_i(ex_pc_i), .ex_is_cond_i(ex_is_cond_i), .ex_is_jal_i(ex_is_jal_i),
        .ex_is_jalr_i(ex_is_jalr_i), .ex_rd_i(ex_rd_i), .ex_rs1_i(ex_rs1_i),
        .ex_cond_taken_i(ex_cond_taken_i), .ex_target_i(ex_target_i),
        .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_pc_i(ex_pred_pc_i),
        .branch_request_o(req), .branch_source_o(src), .branch_target_o(tgt),
        .branch_is_taken_o(taken), .branch_is_call_o(call), .branch_is_ret_o(ret),
        .branch_is_jmp_o(jmp), .branch_mispredict_o(mp), .flush_o(flush),
        .redirect_pc_o(redir), .perf_branch_cnt_o(br_cnt), .perf_mispred_cnt_o(mp_cnt)
    );

    branch_resolve_unit #(.SHADOW_CYCLES(2), .CNT_W(4)) dut_c4 (
        .clk_i(clk_i), .n_rst_i(n_rst_i), .ex_valid_i(ex_valid_i), .stall_i(stall_i),
        .ex_pc_i(ex_pc_i), .ex_is_cond_i(ex_is_cond_i), .ex_is_jal_i(ex_is_jal_i),
        .ex_is_jalr_i(ex_is_jalr_i), .ex_rd_i(ex_rd_i), .ex_rs1_i(ex_rs1_i),
        .ex_cond_taken_i(ex_cond_taken_i), .ex_target_i(ex_target_i),
        .ex_pred_taken_i(ex_pred_taken_i), .ex_pred_pc_i(ex_pred_pc_i),
        .branch_request_o(req4), .branch_source_o(src4), .branch_target_o(tgt4),
        .branch_is_taken_o(taken4), .branch_is_call_o(call4), .branch_is_ret_o(ret4),
        .branch_is_jmp_o(jmp4), .branch_mispredict_o(mp4), .flush_o(flush4),
        .redirect_pc_o(redir4), .perf_branch_cnt_o(br_cnt4), .perf_mispred_cnt_o(mp_cnt4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_br(input logic cond, input logic jal, input logic jalr,
                          input logic [31:0] pc, input logic [31:0] target,
                          input logic [31:0] pred, input logic ctaken,
                          input logic [4:0] rd, input logic [4:0] rs1);
        ex_valid_i      = 1'b1;
        stall_i         = 1'b0;
        ex_is_cond_i    = cond;
        ex_is_jal_i     = jal;
        ex_is_jalr_i    = jalr;
        ex_pc_i         = pc;
        ex_target_i     = target;
        ex_pred_pc_i    = pred;
        ex_pred_taken_i = 1'b0;
        ex_cond_taken_i = ctaken;
        ex_rd_i         = rd;
        ex_rs1_i        = rs1;
    endtask

    task automatic set_idle();
        ex_valid_i   = 1'b0;
        stall_i      = 1'b0;
        ex_is_cond_i = 1'b0;
        ex_is_jal_i  = 1'b0;
        ex_is_jalr_i = 1'b0;
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        // ---- reset state
        tick();
        tick();
        chk("rst_req", req, 0);
        chk("rst_flush", flush, 0);
        chk("rst_br_cnt", br_cnt, 0);
        chk("rst_mp_cnt", mp_cnt, 0);
        chk("rst_redirect", redir, 0);
        #3 n_rst_i = 1'b1;

        // ---- cond taken, correctly predicted
        set_br(1, 0, 0, 32'h100, 32'h80, 32'h80, 1, 0, 0);
        tick(); set_idle();
        chk("c1_req", req, 1);
        chk("c1_taken", taken, 1);
        chk("c1_mp", mp, 0);
        chk("c1_flush", flush, 0);
        chk("c1_src", src, 32'h100);
        chk("c1_tgt", tgt, 32'h80);
        chk("c1_br_cnt", br_cnt, 1);
        tick();
        chk("c1_req_pulse", req, 0);
        chk("c1_src_hold", src, 32'h100);

        // ---- cond not taken, predicted 0x80 -> mispredict, flush to 0x104
        set_br(1, 0, 0, 32'h100, 32'h80, 32'h80, 0, 0, 0);
        tick(); set_idle();
        chk("m1_req", req, 1);
        chk("m1_mp", mp, 1);
        chk("m1_taken", taken, 0);
        chk("m1_flush", flush, 1);
        chk("m1_redirect", redir, 32'h104);
        chk("m1_mp_cnt", mp_cnt, 1);
        tick();
        chk("m1_flush_one", flush, 0);
        chk("m1_no_req_flush", req, 0);
        // stalled shadow cycle does not count
        set_br(0, 1, 0, 32'h200, 32'h300, 32'h300, 0, 0, 0);
        stall_i = 1'b1;
        tick();
        chk("m1_sh_stall", req, 0);
        set_br(0, 1, 0, 32'h200, 32'h300, 32'h300, 0, 0, 0);
        tick();
        chk("m1_sh_disc1", req, 0);
        set_br(0, 1, 0, 32'h204, 32'h300, 32'h300, 0, 0, 0);
        tick();
        chk("m1_sh_disc2", req, 0);
        chk("m1_sh_flush", flush, 0);
        set_br(0, 1, 0, 32'h208, 32'h300, 32'h300, 0, 0, 0);
        tick(); set_idle();
        chk("m1_third_req", req, 1);
        chk("m1_third_src", src, 32'h208);
        chk("m1_br_cnt", br_cnt, 3);
        chk("m1_mp_cnt_after", mp_cnt, 1);

        // ---- classification
        set_br(0, 0, 1, 32'h300, 32'h2000, 32'h2000, 0, 5'd0, 5'd1);
        tick();
        chk("ret_ret", ret, 1);
        chk("ret_jmp", jmp, 0);
        chk("ret_call", call, 0);
        chk("ret_taken", taken, 1);
        set_br(0, 1, 0, 32'h304, 32'h400, 32'h400, 0, 5'd1, 5'd0);
        tick();
        chk("jal_call", call, 1);
        chk("jal_call_jmp", jmp, 0);
        set_br(0, 1, 0, 32'h308, 32'h500, 32'h500, 0, 5'd0, 5'd0);
        tick();
        chk("jal_jmp", jmp, 1);
        chk("jal_jmp_call", call, 0);
        set_br(0, 0, 1, 32'h30C, 32'h600, 32'h600, 0, 5'd5, 5'd1);
        tick();
        chk("jalr_link_call", call, 1);
        chk("jalr_link_ret", ret, 0);
        // jalr wins over cond: taken regardless of compare result
        set_br(1, 0, 1, 32'h310, 32'h700, 32'h700, 0, 5'd0, 5'd0);
        tick();
        chk("prio_taken", taken, 1);
        chk("prio_jmp", jmp, 1);
        chk("prio_mp", mp, 0);
        set_br(1, 0, 0, 32'h500, 32'h600, 32'h504, 0, 5'd0, 5'd0);
        tick();
        chk("nt_ok_mp", mp, 0);
        chk("nt_ok_taken", taken, 0);
        chk("nt_ok_tgt", tgt, 32'h600);
        chk("cls_br_cnt", br_cnt, 9);
        // no class flag -> ignored; invalid -> ignored
        set_br(0, 0, 0, 32'h520, 32'h0, 32'h0, 0, 0, 0);
        tick();
        chk("noclass_req", req, 0);
        set_br(0, 1, 0, 32'h524, 32'h0, 32'h4, 0, 0, 0);
        ex_valid_i = 1'b0;
        tick();
        chk("invalid_req", req, 0);
        chk("ignored_br_cnt", br_cnt, 9);

        // ---- long stall yields one acceptance after release
        set_br(0, 1, 0, 32'h700, 32'h800, 32'h800, 0, 0, 0);
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req", req, 0);
        end
        stall_i = 1'b0;
        tick(); set_idle();
        chk("stall_rel_req", req, 1);
        tick();
        chk("stall_one_pulse", req, 0);
        chk("stall_br_cnt", br_cnt, 10);

        // ---- fall-through wraps to 0 and matches prediction
        set_br(1, 0, 0, 32'hFFFF_FFFC, 32'h10, 32'h0, 0, 0, 0);
        tick(); set_idle();
        chk("wrap_mp", mp, 0);
        chk("wrap_flush", flush, 0);

        // ---- counter saturation (4-bit instance)
        for (int i = 0; i < 20; i++) begin
            set_br(0, 1, 0, 32'h1000, 32'h1100, 32'h1100, 0, 0, 0);
            tick();
        end
        set_idle();
        chk("sat_br_cnt4", br_cnt4, 4'hF);
        chk("sat_br_cnt32", br_cnt, 31);
        for (int i = 0; i < 15; i++) begin
            set_br(0, 1, 0, 32'h900, 32'hA00, 32'h0, 0, 0, 0);
            tick(); set_idle();
            tick(); tick(); tick();
        end
        chk("sat_mp_cnt4", mp_cnt4, 4'hF);
        chk("sat_mp_cnt32", mp_cnt, 16);
        chk("sat_br_cnt32_b", br_cnt, 46);
        chk("sat_br_cnt4_b", br_cnt4, 4'hF);

        // ---- asynchronous reset during SHADOW
        set_br(0, 1, 0, 32'hB00, 32'hC00, 32'h0, 0, 0, 0);
        tick(); set_idle();
        chk("pre_rst_flush", flush, 1);
        tick();
        #2 n_rst_i = 1'b0;
        #1;
        chk("arst_req", req, 0);
        chk("arst_src", src, 0);
        chk("arst_tgt", tgt, 0);
        chk("arst_taken", taken, 0);
        chk("arst_jmp", jmp, 0);
        chk("arst_mp", mp, 0);
        chk("arst_redirect", redir, 0);
        chk("arst_br_cnt", br_cnt, 0);
        chk("arst_mp_cnt", mp_cnt, 0);
        chk("arst_br_cnt4", br_cnt4, 0);
        chk("arst_mp_cnt4", mp_cnt4, 0);
        tick();
        #3 n_rst_i = 1'b1;
        // first branch after release is accepted immediately (FSM in IDLE)
        set_br(1, 0, 0, 32'hD00, 32'hE00, 32'hE00, 1, 0, 0);
        tick(); set_idle();
        chk("post_rst_req", req, 1);
        chk("post_rst_src", src, 32'hD00);
        chk("post_rst_br_cnt", br_cnt, 1);
        chk("post_rst_flush", flush, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Absolute bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
